// File: rtl/inert_spi_serf_if.sv
// SPI link between the monarch and the inertial-sensor serf.
// SS_n, SCLK and MOSI come from the monarch. MISO comes from the serf.
interface inert_spi_serf_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/inert_spi_serf.sv
// Inertial sensor SPI serf: decodes 16-bit command frames into config registers,
// answers reads from a register map and raises a periodic data-ready interrupt.
module inert_spi_serf #(
    parameter int         INT_PERIOD = 4096,
    parameter logic [7:0] WHO_AM_I   = 8'h6A
) (
    input  logic              clk,
    input  logic              rst_n,
    inert_spi_serf_if.slave   spi,
    input  logic [15:0]       ptch_rt,
    input  logic [15:0]       AZ,
    output logic              INT
);
    localparam int TW = (INT_PERIOD > 1) ? $clog2(INT_PERIOD) : 1;

    logic ss_s1_q, ss_s2_q, ss_s3_q, ss_s1_d, ss_s2_d, ss_s3_d;
    logic sclk_s1_q, sclk_s2_q, sclk_s3_q, sclk_s1_d, sclk_s2_d, sclk_s3_d;
    logic mosi_s1_q, mosi_s2_q, mosi_s1_d, mosi_s2_d;
    logic [4:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]   rx_q, rx_d;
    logic [7:0]    tx_q, tx_d;
    logic [7:0]    reg_0d_q, reg_0d_d, reg_10_q, reg_10_d;
    logic [7:0]    reg_11_q, reg_11_d, reg_14_q, reg_14_d;
    logic [15:0]   snap_ptch_q, snap_ptch_d, snap_az_q, snap_az_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          int_q, int_d;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic frame_done, int_en, tick, int_clr;
    logic [7:0] rd_data;

    assign ss_fall    = ss_s3_q & ~ss_s2_q;
    assign ss_rise    = ~ss_s3_q & ss_s2_q;
    assign sclk_rise  = ~sclk_s3_q & sclk_s2_q;
    assign sclk_fall  = sclk_s3_q & ~sclk_s2_q;
    assign frame_done = ss_rise && (bit_cnt_q == 5'd16);
    assign int_en     = reg_0d_q[1];
    assign tick       = int_en && (timer_q == TW'(INT_PERIOD - 1));
    assign int_clr    = frame_done && rx_q[15] && (rx_q[14:8] == 7'h22);

    assign spi.MISO = tx_q[7] & ~ss_s2_q;
    assign INT      = int_q;

    // Address is the low 7 bits of rx once the command byte has been shifted in.
    always_comb begin
        rd_data = 8'h00;
        case (rx_q[6:0])
            7'h0D:   rd_data = reg_0d_q;
            7'h0F:   rd_data = WHO_AM_I;
            7'h10:   rd_data = reg_10_q;
            7'h11:   rd_data = reg_11_q;
            7'h14:   rd_data = reg_14_q;
            7'h22:   rd_data = snap_ptch_q[7:0];
            7'h23:   rd_data = snap_ptch_q[15:8];
            7'h2C:   rd_data = snap_az_q[7:0];
            7'h2D:   rd_data = snap_az_q[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    always_comb begin
        ss_s1_d     = spi.SS_n;
        ss_s2_d     = ss_s1_q;
        ss_s3_d     = ss_s2_q;
        sclk_s1_d   = spi.SCLK;
        sclk_s2_d   = sclk_s1_q;
        sclk_s3_d   = sclk_s2_q;
        mosi_s1_d   = spi.MOSI;
        mosi_s2_d   = mosi_s1_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        reg_0d_d    = reg_0d_q;
        reg_10_d    = reg_10_q;
        reg_11_d    = reg_11_q;
        reg_14_d    = reg_14_q;
        snap_ptch_d = snap_ptch_q;
        snap_az_d   = snap_az_q;
        timer_d     = timer_q;
        int_d       = int_q;

        if (ss_fall) begin
            bit_cnt_d = 5'd0;
            rx_d      = 16'h0000;
            tx_d      = 8'h00;
        end else if (!ss_s2_q) begin
            if (sclk_rise) begin
                rx_d = {rx_q[14:0], mosi_s2_q};
                if (bit_cnt_q != 5'd16)
                    bit_cnt_d = bit_cnt_q + 5'd1;
            end
            if (sclk_fall) begin
                if (bit_cnt_q == 5'd8) begin
                    if (rx_q[7])
                        tx_d = rd_data;
                end else if (bit_cnt_q > 5'd8) begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
        end

        if (frame_done && !rx_q[15]) begin
            case (rx_q[14:8])
                7'h0D:   reg_0d_d = rx_q[7:0];
                7'h10:   reg_10_d = rx_q[7:0];
                7'h11:   reg_11_d = rx_q[7:0];
                7'h14:   reg_14_d = rx_q[7:0];
                default: ;
            endcase
        end

        // A clear in the same cycle as a tick wins; that tick is simply lost.
        if (!int_en) begin
            timer_d = '0;
            int_d   = 1'b0;
        end else begin
            timer_d = tick ? '0 : timer_q + TW'(1);
            if (int_clr) begin
                int_d = 1'b0;
            end else if (tick && !int_q) begin
                snap_ptch_d = ptch_rt;
                snap_az_d   = AZ;
                int_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_s1_q     <= 1'b1;
            ss_s2_q     <= 1'b1;
            ss_s3_q     <= 1'b1;
            sclk_s1_q   <= 1'b0;
            sclk_s2_q   <= 1'b0;
            sclk_s3_q   <= 1'b0;
            mosi_s1_q   <= 1'b0;
            mosi_s2_q   <= 1'b0;
            bit_cnt_q   <= 5'd0;
            rx_q        <= 16'h0000;
            tx_q        <= 8'h00;
            reg_0d_q    <= 8'h00;
            reg_10_q    <= 8'h00;
            reg_11_q    <= 8'h00;
            reg_14_q    <= 8'h00;
            snap_ptch_q <= 16'h0000;
            snap_az_q   <= 16'h0000;
            timer_q     <= '0;
            int_q       <= 1'b0;
        end else begin
            ss_s1_q     <= ss_s1_d;
            ss_s2_q     <= ss_s2_d;
            ss_s3_q     <= ss_s3_d;
            sclk_s1_q   <= sclk_s1_d;
            sclk_s2_q   <= sclk_s2_d;
            sclk_s3_q   <= sclk_s3_d;
            mosi_s1_q   <= mosi_s1_d;
            mosi_s2_q   <= mosi_s2_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            reg_0d_q    <= reg_0d_d;
            reg_10_q    <= reg_10_d;
            reg_11_q    <= reg_11_d;
            reg_14_q    <= reg_14_d;
            snap_ptch_q <= snap_ptch_d;
            snap_az_q   <= snap_az_d;
            timer_q     <= timer_d;
            int_q       <= int_d;
        end
    end
endmodule

// File: doc/inert_spi_serf.md
Name: inert_spi_serf

Overview:
- SPI serf (slave) model of the inertial sensor that responds to the 16-bit command frames issued by the inertial interface state machine through the SPI monarch.
- Decodes write frames into configuration registers and answers read frames with pitch-rate and Z-acceleration bytes.
- After its interrupt is enabled, it periodically snapshots sensor values and raises INT (data ready).
- Used as the sensor end of the link in system and unit testbenches; fully synthesizable.

Parameters:
- INT_PERIOD, 4096: clk cycles between data-ready events; minimum 64.
- WHO_AM_I, 8'h6A: value returned for reads of address 0x0F.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  serf select, active low, asynchronous to clk
- SCLK  input  1  SPI clock from the monarch (mode 0), asynchronous to clk
- MOSI  input  1  monarch-out data
- MISO  output  1  serf-out data
- ptch_rt  input  16  live pitch-rate value to be snapshotted
- AZ  input  16  live Z-acceleration value to be snapshotted
- INT  output  1  data-ready interrupt, active high

Behaviour:
- Reset values: MISO=0, INT=0, all config registers 8'h00, snapshot registers 16'h0000, timer 0, bit counter 0.
- Input synchronization: SS_n, SCLK and MOSI are each double-flopped. A third flop on SCLK provides edge detection: rise = prev 0 / now 1; fall = prev 1 / now 0. SS_n synchronizers reset to 1; the others reset to 0.
- Frame format, MSB first, 16 bits:
  - bit15 R/W_n (1 = read).
  - bits14:8 address.
  - bits7:0 write data (ignored on reads).
- Framing:
  - Falling edge of synchronized SS_n clears the bit counter, the rx shift register and the tx register.
  - Each SCLK rise while SS_n is low shifts the synced MOSI into rx bit 0 and increments the 5-bit bit counter, which saturates at 16.
- Read response:
  - On the first SCLK fall after bit count reaches 8, if rx[7] (R/W_n) = 1, tx[7:0] is loaded with the read data for address rx[6:0].
  - Each later SCLK fall shifts tx left and fills with 0.
  - MISO = tx[7] while SS_n is low, else 0. MISO is 0 during bits 15:8.
- Read map:
  - 0x0D, 0x10, 0x11, 0x14: the config register value.
  - 0x0F: WHO_AM_I.
  - 0x22: snap_ptch[7:0]; 0x23: snap_ptch[15:8].
  - 0x2C: snap_AZ[7:0]; 0x2D: snap_AZ[15:8].
  - All other addresses: 8'h00.
- Frame completion: on the SS_n rising edge with bit count == 16.
  - Write (bit15 = 0) to 0x0D, 0x10, 0x11 or 0x14 updates that register with rx[7:0]. Writes to other addresses are ignored.
  - Completed read of 0x22 clears INT on the next clk.
- Aborted frame: SS_n rising with bit count != 16. No register update, no INT clear.
- INT enable: reg 0x0D bit1 (the value 8'h02 written at init).
  - While disabled, the timer is held at 0 and INT is forced low.
  - Clearing bit1 also clears INT at once.
- Data-ready timer:
  - While enabled, the timer counts clk cycles up to INT_PERIOD-1, then wraps to 0 and fires a tick.
  - On a tick with INT=0: snap_ptch<=ptch_rt, snap_AZ<=AZ, INT<=1, all in the same clk.
  - On a tick with INT=1 (overrun): snapshots are unchanged and INT stays 1.
- Snapshot coherence: snapshots never change while INT=1, so all four bytes of one read burst come from a single sample.
- Simultaneous events: if a tick and an INT clear occur in the same clk, the clear wins and the tick is dropped. The next tick follows INT_PERIOD later.
- Reset mid-frame: everything returns to reset values. A frame in flight is lost, and the serf resynchronizes on the next SS_n fall.

Test Plan:
- Reset, idle SS_n=1, 20000 clks -> MISO=0, INT=0 throughout (interrupt not enabled).
- Write frames 16'h0D02, 16'h1053, 16'h1150, 16'h1460, then read 16'h8D00 and 16'h9000 -> MISO second bytes 8'h02 and 8'h53; read 16'h8F00 -> 8'h6A.
- After 0x0D=02, ptch_rt=16'h1234 and AZ=16'hABCD -> INT rises INT_PERIOD clks later. Change ptch_rt to 16'h5555, then read A2, A3, AC, AD -> bytes 34, 12, CD, AB. INT drops after the A2 frame ends.
- Hold INT unserviced for 3*INT_PERIOD while inputs change -> INT stays 1; the later read returns the first snapshot.
- Frame aborted after 10 SCLKs carrying 16'h1099 -> reg 0x10 unchanged (still 8'h53 on readback).
- Assert rst_n low during bit 12 of a read frame -> MISO=0, INT=0, regs 0. The next full 16'h8D00 read returns 8'h00.
